// File: rtl/spi_wb_ctrl_pkg.sv
// spi_wb_ctrl_pkg: shared definitions for the SPI-to-Wishbone sequencer.
//   CMD byte bit positions, FSM state encoding, data returned on a
//   timed-out read.
package spi_wb_ctrl_pkg;

  localparam int CMD_READ_BIT = 7;
  localparam int CMD_INCR_BIT = 6;
  localparam int CMD_A16_BIT  = 0;

  localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [2:0] {
    CMD,
    ADDR_HI,
    ADDR_LO,
    DATA,
    BUS_RD,
    BUS_WR,
    NEXT
  } state_t;

endpackage

// File: rtl/spi_wb_ctrl_sync2.sv
// spi_wb_ctrl_sync2: two-flop synchroniser for a single-bit level.
//   clk    destination clock
//   rst_n  asynchronous active-low reset (both flops load RESET_VAL)
//   d      asynchronous input
//   q      synchronised output
module spi_wb_ctrl_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_wb_ctrl.sv
// spi_wb_ctrl: Wishbone master sequencer fed by the SPI byte engine.
//   Frames are CMD / ADDR_HI / ADDR_LO / DATA; reads are issued right after
//   ADDR_LO and the result is handed back on spi_data_o for the next byte.
// Ports:
//   wb_clock_i, wb_reset_ni        clock, async active-low reset
//   spi_cs_ni, spi_strobe_i        raw SCK-domain chip select / byte strobe
//   spi_data_i, spi_data_o         received byte / next byte to shift out
//   wb_*                           pipelined Wishbone master
//   busy_o                         bus cycle outstanding
//   overrun_o                      sticky: byte arrived while busy
//   timeout_o                      sticky watchdog flag (only with the macro)
// Optional feature macro: SPI_WB_CTRL_TIMEOUT_EN (bus watchdog + timeout_o).
//
// state   | meaning
// CMD     | waiting for command byte
// ADDR_HI | waiting for address bits 15:8
// ADDR_LO | waiting for address bits 7:0
// DATA    | waiting for a write data byte
// BUS_RD  | read cycle on the bus
// BUS_WR  | write cycle on the bus
// NEXT    | transfer done; terminal unless auto-increment
module spi_wb_ctrl
  import spi_wb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_ni,
  input  logic                  spi_cs_ni,
  input  logic                  spi_strobe_i,
  input  logic [DATA_WIDTH-1:0] spi_data_i,
  output logic [DATA_WIDTH-1:0] spi_data_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_we_o,
  output logic                  wb_cycle_o,
  output logic                  wb_strobe_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i,
  output logic                  busy_o,
  output logic                  overrun_o
`ifdef SPI_WB_CTRL_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);

  state_t state;
  logic   strobe_s, strobe_d, cs_s, cs_d;
  logic   byte_ev, cs_rise, bus_done, tmo_hit;
  logic   rd, incr, cs_pend;

  spi_wb_ctrl_sync2 #(.RESET_VAL(1'b0)) u_sync_strobe (
    .clk(wb_clock_i), .rst_n(wb_reset_ni), .d(spi_strobe_i), .q(strobe_s)
  );

  spi_wb_ctrl_sync2 #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(wb_clock_i), .rst_n(wb_reset_ni), .d(spi_cs_ni), .q(cs_s)
  );

  assign byte_ev  = strobe_s & ~strobe_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign busy_o   = wb_cycle_o;
  assign bus_done = wb_cycle_o & (wb_ack_i | tmo_hit);

`ifdef SPI_WB_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Reloaded whenever the bus is idle; hits zero on the last allowed clock.
  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (!wb_cycle_o) begin
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end

  assign tmo_hit = wb_cycle_o && (tmo_cnt == '0);
`else
  // Watchdog compiled out: the comparison folds to a constant 0.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state       <= CMD;
      strobe_d    <= 1'b0;
      cs_d        <= 1'b1;
      rd          <= 1'b0;
      incr        <= 1'b0;
      cs_pend     <= 1'b0;
      spi_data_o  <= '0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_we_o     <= 1'b0;
      wb_cycle_o  <= 1'b0;
      wb_strobe_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef SPI_WB_CTRL_TIMEOUT_EN
      timeout_o   <= 1'b0;
`endif
    end else begin
      strobe_d <= strobe_s;
      cs_d     <= cs_s;

      if (wb_cycle_o) begin
        // Bytes are dropped while a cycle is open; the FSM stays put.
        if (byte_ev) overrun_o <= 1'b1;
        if (wb_strobe_o && !wb_stall_i) wb_strobe_o <= 1'b0;
        // A CS rise never truncates the cycle; remember it for completion.
        if (cs_rise) begin
          cs_pend <= 1'b1;
          incr    <= 1'b0;
        end
        if (bus_done) begin
          wb_cycle_o  <= 1'b0;
          wb_strobe_o <= 1'b0;
          wb_we_o     <= 1'b0;
          if (!wb_we_o) spi_data_o <= wb_ack_i ? wb_data_i : RD_TIMEOUT_DATA;
`ifdef SPI_WB_CTRL_TIMEOUT_EN
          if (!wb_ack_i) timeout_o <= 1'b1;
`endif
          if (cs_pend || cs_rise) begin
            state   <= CMD;
            cs_pend <= 1'b0;
          end else begin
            state <= NEXT;
            if (incr) wb_addr_o <= wb_addr_o + ADDR_WIDTH'(1);
          end
        end
      end else if (cs_rise) begin
        state <= CMD;
        incr  <= 1'b0;
      end else begin
        unique case (state)
          CMD: if (byte_ev) begin
            rd            <= spi_data_i[CMD_READ_BIT];
            incr          <= spi_data_i[CMD_INCR_BIT];
            wb_addr_o[16] <= spi_data_i[CMD_A16_BIT];
            overrun_o     <= 1'b0;
`ifdef SPI_WB_CTRL_TIMEOUT_EN
            timeout_o     <= 1'b0;
`endif
            state         <= ADDR_HI;
          end
          ADDR_HI: if (byte_ev) begin
            wb_addr_o[15:8] <= spi_data_i;
            state           <= ADDR_LO;
          end
          ADDR_LO: if (byte_ev) begin
            wb_addr_o[7:0] <= spi_data_i;
            if (rd) begin
              wb_cycle_o  <= 1'b1;
              wb_strobe_o <= 1'b1;
              wb_we_o     <= 1'b0;
              state       <= BUS_RD;
            end else begin
              state <= DATA;
            end
          end
          DATA: if (byte_ev) begin
            wb_data_o   <= spi_data_i;
            wb_cycle_o  <= 1'b1;
            wb_strobe_o <= 1'b1;
            wb_we_o     <= 1'b1;
            state       <= BUS_WR;
          end
          NEXT: if (incr) begin
            if (!rd) begin
              state <= DATA;
            end else if (byte_ev) begin
              // Dummy byte carried the previous result out; fetch the next.
              wb_cycle_o  <= 1'b1;
              wb_strobe_o <= 1'b1;
              wb_we_o     <= 1'b0;
              state       <= BUS_RD;
            end
          end
          default: state <= CMD;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_wb_ctrl.md
Name: spi_wb_ctrl

Overview:
- Wishbone master sequencer driven by the SPI byte engine (spi, DATA_WIDTH=8).
- Takes received bytes and strobes from the SCK domain and synchronises them into the wb clock domain.
- Parses a CMD / ADDR_HI / ADDR_LO / DATA framing and issues single or auto-incrementing bus reads and writes.
- Presents read data back to the engine for shifting out. Gives the MCU access to the PET address space over SPI.

Parameters:
- ADDR_WIDTH, 17, Wishbone address width. Bit 16 comes from CMD[0]; bits 15:0 come from the two address bytes.
- DATA_WIDTH, 8, byte width. Must match the spi engine.
- TIMEOUT_CYCLES, 255, bus-cycle watchdog limit in wb clocks. Used only when the optional feature is enabled.

Ports:
- wb_clock_i  in  1  system/Wishbone clock.
- wb_reset_ni  in  1  asynchronous, active-low reset.
- spi_cs_ni  in  1  raw SPI chip select (SCK/async domain).
- spi_strobe_i  in  1  spi strobe_o (SCK domain). High for one SCK period per received byte.
- spi_data_i  in  DATA_WIDTH  spi data_o. Stable from the strobe until the next byte's LSB.
- spi_data_o  out  DATA_WIDTH  to spi data_i. Next byte to transmit.
- wb_addr_o  out  ADDR_WIDTH  bus address.
- wb_data_o  out  DATA_WIDTH  write data.
- wb_data_i  in  DATA_WIDTH  read data.
- wb_we_o  out  1  write enable.
- wb_cycle_o  out  1  cycle valid.
- wb_strobe_o  out  1  transfer request (pipelined Wishbone).
- wb_stall_i  in  1  slave stall.
- wb_ack_i  in  1  slave acknowledge.
- busy_o  out  1  bus cycle outstanding.
- overrun_o  out  1  sticky: a byte arrived while busy_o was high.

Behaviour:
- Reset: all outputs are 0, spi_data_o = 8'h00, state = CMD, address = 0.
- CDC:
  - spi_strobe_i and spi_cs_ni each pass through a 2-flop synchroniser.
  - A rising edge of the synchronised strobe is one byte event. Latency is 3 clocks from rising SCK.
  - spi_data_i is sampled on the byte event.
  - SCK high time must be at least 2 wb clocks.
- CMD byte fields:
  - [7] = read.
  - [6] = incr.
  - [5:1] reserved; ignored.
  - [0] = A16.
  - A CMD byte clears overrun_o.
- State machine:
  - CMD -> ADDR_HI -> ADDR_LO on successive byte events.
  - After ADDR_LO:
    - Read: go to BUS_RD. Issue a read immediately.
    - Write: go to DATA and wait for a byte.
  - DATA: on a byte event, latch wb_data_o and go to BUS_WR.
  - BUS_RD / BUS_WR:
    - Assert cycle, strobe and we (we for BUS_WR only).
    - Drop strobe on the first clock with wb_stall_i low.
    - Hold cycle until wb_ack_i.
  - On ack:
    - Read: load spi_data_o <= wb_data_i. This byte shifts out on the next SPI byte.
    - Then go to NEXT.
  - NEXT:
    - If incr = 0, terminal. Further bytes are ignored until CS rises.
    - If incr = 1, the address increments. Wrap from 2^ADDR_WIDTH-1 to 0.
    - Write: return to DATA.
    - Read: wait for the next byte event (the dummy byte carrying the previous data out), then go to BUS_RD.
- Host contract: after the ADDR_LO byte or a read-dummy byte, the host waits at least 3 + bus latency + 2 clocks before the next MSB.
- Byte event while busy_o: byte is dropped, overrun_o is set, and the state is unchanged.
- Synchronised CS rise:
  - State returns to CMD.
  - A bus cycle in flight completes normally; it is never truncated. A pending read result is still loaded.
  - incr is cleared.
- CS rise and ack in the same clock: the ack is processed, then state goes to CMD.
- Async reset mid-cycle drops wb_cycle_o immediately.

Optional Feature:
- Macro SPI_WB_CTRL_TIMEOUT_EN.
- Defined:
  - A counter runs while wb_cycle_o is high.
  - At TIMEOUT_CYCLES without ack, the cycle is abandoned and cycle/strobe are dropped.
  - A read returns 8'hFF.
  - timeout_o (extra output port, sticky, cleared by a CMD byte) is set.
  - Sequencing continues as if acked.
- Undefined: no counter and no timeout_o port; the controller waits on ack indefinitely.

Decomposition:
- Package spi_wb_ctrl_pkg:
  - CMD bit positions (CMD_READ_BIT=7, CMD_INCR_BIT=6, CMD_A16_BIT=0).
  - state_t enum {CMD, ADDR_HI, ADDR_LO, DATA, BUS_RD, BUS_WR, NEXT}.
  - Read-timeout value 8'hFF.
- Sub-module sync2: a 2-flop synchroniser with reset value parameter, instantiated for strobe (reset 0) and CS (reset 1).

Test Plan:
- Write: CMD=8'h01, 8'h23, 8'h45, data 8'hA5 -> one WB write with addr=17'h12345, data=A5, we=1; then terminal; an extra byte is ignored.
- Read: CMD=8'h80, 8'h80, 8'h00 with slave returning 8'h3C after 2 stalls -> strobe drops after the stall ends, and spi_data_o=3C before the dummy byte.
- Incr write at 17'h1FFFF: CMD=8'h41, FF, FF, then bytes 11, 22 -> writes to 1FFFF then 00000.
- Overrun: byte event while ack is withheld -> byte dropped, overrun_o=1; the next CMD byte clears it.
- CS rises during BUS_RD -> cycle completes on ack, spi_data_o is loaded, state=CMD; a new write frame works.
- With SPI_WB_CTRL_TIMEOUT_EN and no ack -> cycle drops after 255 clocks, spi_data_o=FF, timeout_o=1.
